parallel_to_serial: RTL and testbench

PARALLEL_TO_SERIAL -- requirements
Module: parallel_to_serial

---
 rtl/p2s_pkg.sv | 15 +
 rtl/p2s_hold_buf.sv | 26 ++
 rtl/parallel_to_serial.sv | 129 ++++++++++++
 tb/tb_parallel_to_serial.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p2s_pkg.sv
// Shared constants and types for the parallel_to_serial byte serializer.
package p2s_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned NUM_BYTES = 8;
  localparam int unsigned IDX_W     = 3;

  typedef logic [NUM_BYTES-1:0][BYTE_W-1:0] frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/p2s_hold_buf.sv
// One-frame holding register with valid flag; lets the next frame be accepted while the current one shifts.
module p2s_hold_buf
  import p2s_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   wr_en,
  input  logic   rd_en,
  input  frame_t wr_data,
  output logic   hold_valid,
  output frame_t hold_data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (wr_en) begin
      hold_valid <= 1'b1;
      hold_data  <= wr_data;
    end else if (rd_en) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/parallel_to_serial.sv
// Eight-byte frame serializer, D7 first, D0 last (flagged by q_last).
// Define P2S_PRELOAD_EN to add a hold buffer for gap-free back-to-back frames.
module parallel_to_serial
  import p2s_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] D0,
  input  logic [BYTE_W-1:0] D1,
  input  logic [BYTE_W-1:0] D2,
  input  logic [BYTE_W-1:0] D3,
  input  logic [BYTE_W-1:0] D4,
  input  logic [BYTE_W-1:0] D5,
  input  logic [BYTE_W-1:0] D6,
  input  logic [BYTE_W-1:0] D7,
  input  logic              load_valid,
  output logic              load_ready,
  output logic [BYTE_W-1:0] q_data,
  output logic              q_valid,
  input  logic              q_ready,
  output logic              q_last
);

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx, idx_next;
  frame_t             frame, frame_src, d_bus;
  logic               frame_ld;
  logic               load_hs;

  assign d_bus   = {D7, D6, D5, D4, D3, D2, D1, D0};
  assign load_hs = load_valid && load_ready;

`ifdef P2S_PRELOAD_EN
  logic   hold_valid, hold_wr, hold_rd;
  frame_t hold_data;

  p2s_hold_buf u_hold (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (hold_wr),
    .rd_en      (hold_rd),
    .wr_data    (d_bus),
    .hold_valid (hold_valid),
    .hold_data  (hold_data)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '1;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame <= '0;
    end else if (frame_ld) begin
      frame <= frame_src;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    frame_ld   = 1'b0;
    frame_src  = d_bus;
`ifdef P2S_PRELOAD_EN
    hold_rd    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (load_hs) begin
          state_next = SHIFT;
          idx_next   = '1;
          frame_ld   = 1'b1;
        end
      end
      SHIFT: begin
        if (q_ready) begin
          if (idx != '0) begin
            idx_next = idx - 1'b1;
          end else begin
`ifdef P2S_PRELOAD_EN
            // Last byte leaving: chain the held frame, else a frame arriving this very edge.
            if (hold_valid) begin
              frame_ld  = 1'b1;
              frame_src = hold_data;
              idx_next  = '1;
              hold_rd   = 1'b1;
            end else if (load_hs) begin
              frame_ld = 1'b1;
              idx_next = '1;
            end else begin
              state_next = IDLE;
              idx_next   = '1;
            end
`else
            state_next = IDLE;
            idx_next   = '1;
`endif
          end
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '1;
      end
    endcase
`ifdef P2S_PRELOAD_EN
    hold_wr = load_hs && (state == SHIFT) && !frame_ld;
`endif
  end

  always_comb begin
    q_valid = (state == SHIFT);
    q_data  = q_valid ? frame[idx] : '0;
    q_last  = q_valid && (idx == '0);
`ifdef P2S_PRELOAD_EN
    load_ready = !reset && ((state == IDLE) || !hold_valid);
`else
    load_ready = !reset && (state == IDLE);
`endif
  end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Self-checking bench for parallel_to_serial; expectations follow P2S_PRELOAD_EN when defined.
module tb_parallel_to_serial;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d [8];
  logic       load_valid, load_ready;
  logic [7:0] q_data;
  logic       q_valid, q_ready, q_last;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parallel_to_serial dut (
    .clk        (clk),
    .reset      (reset),
    .D0         (d[0]),
    .D1         (d[1]),
    .D2         (d[2]),
    .D3         (d[3]),
    .D4         (d[4]),
    .D5         (d[5]),
    .D6         (d[6]),
    .D7         (d[7]),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .q_data     (q_data),
    .q_valid    (q_valid),
    .q_ready    (q_ready),
    .q_last     (q_last)
  );

  task automatic drive_frame(input logic [7:0][7:0] f);
    for (int k = 0; k < 8; k++) d[k] = f[k];
  endtask

  task automatic test_reset;
    logic [7:0][7:0] f;
    for (int k = 0; k < 8; k++) f[k] = 8'($urandom);
    drive_frame(f);
    reset = 1'b1; load_valid = 1'b1; q_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (q_valid !== 1'b0 || q_last !== 1'b0 || q_data !== 8'h00) begin
        errors++;
        $display("FAIL reset_outputs c=%0d got v=%b l=%b d=%h exp v=0 l=0 d=00", c, q_valid, q_last, q_data);
      end
      checks++;
      if (load_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_load_ready c=%0d got %b exp 0", c, load_ready);
      end
    end
    reset = 1'b0; load_valid = 1'b0;
    #1;
    checks++;
    if (load_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_load_ready got %b exp 1", load_ready);
    end
    @(negedge clk);
    checks++;
    if (q_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ignores_load got q_valid=%b exp 0", q_valid);
    end
  endtask

  task automatic test_basic;
    logic [7:0][7:0] f;
    logic            ev, el;
    logic [7:0]      ed;
    for (int k = 0; k < 8; k++) f[k] = 8'(8'h10 + k);
    @(negedge clk);
    drive_frame(f); load_valid = 1'b1; q_ready = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      load_valid = 1'b0;
      ev = (c <= 8);
      ed = ev ? f[8-c] : 8'h00;
      el = (c == 8);
      checks++;
      if (q_valid !== ev || q_data !== ed || q_last !== el) begin
        errors++;
        $display("FAIL basic c=%0d got v=%b d=%h l=%b exp v=%b d=%h l=%b", c, q_valid, q_data, q_last, ev, ed, el);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [7:0][7:0] f;
    int              pos, beats;
    logic            ev, el;
    logic [7:0]      ed;
    for (int k = 0; k < 8; k++) f[k] = 8'(8'h10 + k);
    pos = 7; beats = 0;
    @(negedge clk);
    drive_frame(f); load_valid = 1'b1; q_ready = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      load_valid = 1'b0;
      q_ready = !(c >= 3 && c <= 5);
      ev = (pos >= 0);
      ed = ev ? f[pos] : 8'h00;
      el = (pos == 0);
      checks++;
      if (q_valid !== ev || q_data !== ed || q_last !== el) begin
        errors++;
        $display("FAIL backpressure c=%0d got v=%b d=%h l=%b exp v=%b d=%h l=%b", c, q_valid, q_data, q_last, ev, ed, el);
      end
      if (q_valid && q_ready) begin
        beats++;
        pos--;
      end
    end
    checks++;
    if (beats !== 8) begin
      errors++;
      $display("FAIL backpressure_beats got %0d exp 8", beats);
    end
    q_ready = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic [7:0][7:0] a, b;
    int              stage;
    logic            acc, ev, elr;
    logic [7:0]      ed;
    for (int k = 0; k < 8; k++) begin
      a[k] = 8'($urandom);
      b[k] = 8'($urandom);
    end
    stage = 0; acc = 1'b0;
    @(negedge clk);
    drive_frame(a); load_valid = 1'b1; q_ready = 1'b1;
    acc = load_ready;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
`ifdef P2S_PRELOAD_EN
      ev  = (c <= 16);
      ed  = (c <= 8) ? a[8-c] : ((c <= 16) ? b[16-c] : 8'h00);
      elr = (c == 1) || (c >= 9);
`else
      ev  = (c <= 8) || (c >= 10 && c <= 17);
      ed  = (c <= 8) ? a[8-c] : ((c >= 10 && c <= 17) ? b[17-c] : 8'h00);
      elr = !ev;
`endif
      checks++;
      if (q_valid !== ev || q_data !== ed) begin
        errors++;
        $display("FAIL back_to_back c=%0d got v=%b d=%h exp v=%b d=%h", c, q_valid, q_data, ev, ed);
      end
      checks++;
      if (load_ready !== elr) begin
        errors++;
        $display("FAIL back_to_back_ready c=%0d got %b exp %b", c, load_ready, elr);
      end
      if (acc) begin
        stage++;
        if (stage == 1) drive_frame(b);
        else load_valid = 1'b0;
      end
      acc = load_valid && load_ready;
    end
    load_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [7:0][7:0] f, g;
    for (int k = 0; k < 8; k++) begin
      f[k] = 8'($urandom);
      g[k] = 8'($urandom);
    end
    @(negedge clk);
    drive_frame(f); load_valid = 1'b1; q_ready = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      load_valid = 1'b0;
      checks++;
      if (q_valid !== 1'b1 || q_data !== f[8-c]) begin
        errors++;
        $display("FAIL mid_pre c=%0d got v=%b d=%h exp v=1 d=%h", c, q_valid, q_data, f[8-c]);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (q_valid !== 1'b0 || q_data !== 8'h00 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got v=%b d=%h lr=%b exp v=0 d=00 lr=0", q_valid, q_data, load_ready);
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (q_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_abort c=%0d got v=%b d=%h exp v=0", c, q_valid, q_data);
      end
    end
    drive_frame(g); load_valid = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      load_valid = 1'b0;
      checks++;
      if (q_valid !== 1'b1 || q_data !== g[8-c]) begin
        errors++;
        $display("FAIL mid_restart c=%0d got v=%b d=%h exp v=1 d=%h", c, q_valid, q_data, g[8-c]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_loopback;
    logic [7:0][7:0] f;
    logic [7:0]      chain [8];
    int              beats, w;
    logic            done;
    for (int n = 0; n < 100; n++) begin
      for (int k = 0; k < 8; k++) f[k] = 8'($urandom);
      w = 0;
      while (!load_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      checks++;
      if (!load_ready) begin
        errors++;
        $display("FAIL loopback_ready_timeout frame=%0d got 0 exp 1", n);
        return;
      end
      drive_frame(f); load_valid = 1'b1;
      beats = 0; done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
        @(negedge clk);
        load_valid = 1'b0;
        q_ready = ($urandom_range(0, 3) != 0);
        if (!q_valid) begin
          checks++;
          if (q_data !== 8'h00) begin
            errors++;
            $display("FAIL loopback_idle_data frame=%0d got %h exp 00", n, q_data);
          end
        end
        if (q_valid && q_ready) begin
          for (int k = 7; k > 0; k--) chain[k] = chain[k-1];
          chain[0] = q_data;
          beats++;
          checks++;
          if (q_last !== (beats == 8)) begin
            errors++;
            $display("FAIL loopback_last frame=%0d beat=%0d got %b exp %b", n, beats, q_last, beats == 8);
          end
          if (beats >= 8) done = 1'b1;
        end
      end
      checks++;
      if (!done) begin
        errors++;
        $display("FAIL loopback_timeout frame=%0d got %0d beats exp 8", n, beats);
      end
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (chain[k] !== f[k]) begin
          errors++;
          $display("FAIL loopback_chain frame=%0d Q%0d got %h exp %h", n, k, chain[k], f[k]);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; q_ready = 1'b0;
    for (int k = 0; k < 8; k++) d[k] = 8'h00;
    test_reset;
    test_basic;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    test_loopback;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
